alu_op_sequencer: RTL and testbench

Command sequencer that sits directly upstream of the BreadBoard ALU. It queues operation commands in a small FIFO, drives the ALU's IN1/IN2/OP from registers, waits a fixed settle time, then captures OUT/ERR into a result register. A result handshake delivers the captured value. A 32-bit accumulator lets consecutive operations chain results. Ops 0000, 0001 and 0111–1111 complete locally without the ALU.

---
 rtl/alu_op_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Command sequencer feeding the BreadBoard ALU: queues commands, holds ALU inputs
// for a settle window, captures OUT/ERR, and hands results out in command order.
module alu_op_sequencer #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [3:0]  cmd_op_i,
    input  logic [15:0] cmd_a_i,
    input  logic [15:0] cmd_b_i,
    input  logic        cmd_use_acc_i,
    output logic [15:0] alu_in1_o,
    output logic [15:0] alu_in2_o,
    output logic [3:0]  alu_op_o,
    input  logic [31:0] alu_out_i,
    input  logic [1:0]  alu_err_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] res_data_o,
    output logic [1:0]  res_err_o,
    output logic [31:0] acc_o,
    output logic        busy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(SETTLE + 1);

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        use_acc;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DONE
    } state_t;

    cmd_t          fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   in1_q, in1_d;
    logic [15:0]   in2_q, in2_d;
    logic [3:0]    op_q, op_d;
    logic [31:0]   res_data_q, res_data_d;
    logic [1:0]    res_err_q, res_err_d;
    logic [31:0]   acc_q, acc_d;

    logic          full;
    logic          push;
    logic          pop;
    cmd_t          head;
    cmd_t          cmd_in;
    logic [15:0]   opa;
    logic [1:0]    err_masked;

    assign full        = (count_q == (AW+1)'(DEPTH));
    assign cmd_ready_o = ~full & ~rst_i;
    assign push        = cmd_valid_i & cmd_ready_o;
    assign pop         = (state_q == ST_IDLE) && (count_q != '0);
    assign head        = fifo_mem[rd_ptr_q];
    assign cmd_in      = '{op: cmd_op_i, a: cmd_a_i, b: cmd_b_i, use_acc: cmd_use_acc_i};
    // Operand A comes from the accumulator as it stands at pop time.
    assign opa         = head.use_acc ? acc_q[15:0] : head.a;

    // Only flags meaningful for the issued op survive: overflow for add/sub,
    // divide-by-zero for div/mod.
    assign err_masked[0] = alu_err_i[0] & ((op_q == 4'd2) || (op_q == 4'd3));
    assign err_masked[1] = alu_err_i[1] & ((op_q == 4'd5) || (op_q == 4'd6));

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        in1_d      = in1_q;
        in2_d      = in2_q;
        op_d       = op_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        acc_d      = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    case (head.op)
                        4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
                            in1_d   = opa;
                            in2_d   = head.b;
                            op_d    = head.op;
                            cnt_d   = CW'(SETTLE);
                            state_d = ST_SETTLE;
                        end
                        4'd0: begin
                            acc_d      = '0;
                            res_data_d = '0;
                            res_err_d  = 2'b00;
                            state_d    = ST_DONE;
                        end
                        4'd1: begin
                            acc_d      = {16'b0, opa};
                            res_data_d = {16'b0, opa};
                            res_err_d  = 2'b00;
                            state_d    = ST_DONE;
                        end
                        default: begin
                            res_data_d = '0;
                            res_err_d  = 2'b11;
                            state_d    = ST_DONE;
                        end
                    endcase
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    res_data_d = alu_out_i;
                    res_err_d  = err_masked;
                    if (err_masked == 2'b00) begin
                        acc_d = alu_out_i;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            in1_q      <= '0;
            in2_q      <= '0;
            op_q       <= '0;
            res_data_q <= '0;
            res_err_q  <= '0;
            acc_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in1_q      <= in1_d;
            in2_q      <= in2_d;
            op_q       <= op_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
            acc_q      <= acc_d;
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= cmd_in;
        end
    end

    assign alu_in1_o   = in1_q;
    assign alu_in2_o   = in2_q;
    assign alu_op_o    = op_q;
    assign res_valid_o = (state_q == ST_DONE);
    assign res_data_o  = res_data_q;
    assign res_err_o   = res_err_q;
    assign acc_o       = acc_q;
    assign busy_o      = (state_q != ST_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural BreadBoard ALU plus an in-order
// result model; directed steps from the test plan followed by random traffic.
module tb_alu_op_sequencer;

    localparam int DEPTH  = 4;
    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        cmd_use_acc;
    logic [15:0] alu_in1;
    logic [15:0] alu_in2;
    logic [3:0]  alu_op;
    logic [31:0] alu_out;
    logic [1:0]  alu_err;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [1:0]  res_err;
    logic [31:0] acc;
    logic        busy;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_a_i      (cmd_a),
        .cmd_b_i      (cmd_b),
        .cmd_use_acc_i(cmd_use_acc),
        .alu_in1_o    (alu_in1),
        .alu_in2_o    (alu_in2),
        .alu_op_o     (alu_op),
        .alu_out_i    (alu_out),
        .alu_err_i    (alu_err),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_data_o   (res_data),
        .res_err_o    (res_err),
        .acc_o        (acc),
        .busy_o       (busy)
    );

    // BreadBoard ALU behaviour: err[1] whenever IN2 is zero, err[0] on 16-bit overflow/borrow.
    function automatic logic [31:0] bb_out(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        case (op)
            4'd2:    return 32'(x) + 32'(y);
            4'd3:    return 32'(x) - 32'(y);
            4'd4:    return 32'(x) * 32'(y);
            4'd5:    return (y == 0) ? 32'd0 : 32'(x / y);
            4'd6:    return (y == 0) ? 32'd0 : 32'(x % y);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [1:0] bb_err(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        logic [1:0] e;
        e[1] = (y == 16'd0);
        case (op)
            4'd2:    e[0] = (32'(x) + 32'(y)) > 32'hFFFF;
            4'd3:    e[0] = (x < y);
            4'd4:    e[0] = (32'(x) * 32'(y)) > 32'hFFFF;
            default: e[0] = 1'b0;
        endcase
        return e;
    endfunction

    assign alu_out = bb_out(alu_op, alu_in1, alu_in2);
    assign alu_err = bb_err(alu_op, alu_in1, alu_in2);

    typedef struct {
        logic [31:0] data;
        logic [1:0]  err;
        logic [31:0] acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] acc_m;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: commands complete one at a time in order, so the accumulator
    // seen at pop is the one left by the previous command.
    task automatic model_push(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic u);
        exp_t        r;
        logic [15:0] x;
        logic [1:0]  raw;
        x = u ? acc_m[15:0] : a;
        case (op)
            4'd0: begin r.data = 0; r.err = 2'b00; acc_m = 0; end
            4'd1: begin r.data = {16'h0, x}; r.err = 2'b00; acc_m = r.data; end
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
                r.data = bb_out(op, x, b);
                raw    = bb_err(op, x, b);
                r.err  = {raw[1] & (op == 4'd5 || op == 4'd6), raw[0] & (op == 4'd2 || op == 4'd3)};
                if (r.err == 2'b00) acc_m = r.data;
            end
            default: begin r.data = 0; r.err = 2'b11; end
        endcase
        r.acc = acc_m;
        exp_q.push_back(r);
    endtask

    // Called just after a negedge; returns just after the negedge following the accepting edge.
    task automatic push_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic u);
        int w;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = u; cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            chk("push_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_push(op, a, b, u);
        @(negedge clk);
        cmd_valid = 1'b0;
        $display("push op=%0h a=%0h b=%0h use_acc=%0b", op, a, b, u);
    endtask

    task automatic pop_res(input int hold, output int lat);
        exp_t r;
        lat = 0;
        while (!res_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("res_valid_wait", 32'(res_valid), 32'd1);
        if (!res_valid) return;
        if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'(exp_q.size()), 32'd1);
            return;
        end
        r = exp_q.pop_front();
        chk("res_data", res_data, r.data);
        chk("res_err", 32'(res_err), 32'(r.err));
        chk("acc", acc, r.acc);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_data", res_data, r.data);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk("valid_drop", 32'(res_valid), 32'd0);
        $display("result data=%0h err=%0b acc=%0h lat=%0d", r.data, r.err, r.acc, lat);
    endtask

    initial begin
        int lat;
        int accepted;
        int n;
        logic [3:0]  rop;
        logic [15:0] ra, rb;
        int r;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
        cmd_use_acc = 1'b0; res_ready = 1'b0; acc_m = 0;

        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_acc", acc, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_alu_in1", 32'(alu_in1), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);

        // ADD 11+51: result visible SETTLE+1 edges after acceptance.
        push_cmd(4'd2, 16'd11, 16'd51, 1'b0);
        pop_res(0, lat);
        chk("add_latency", 32'(lat), 32'(SETTLE + 1));
        chk("add_acc", acc, 32'd62);

        push_cmd(4'd1, 16'd5, 16'd0, 1'b0);
        pop_res(1, lat);
        chk("load_latency", 32'(lat), 32'd1);
        push_cmd(4'd4, 16'd0, 16'd7, 1'b1);
        pop_res(0, lat);
        chk("mul_acc", acc, 32'd35);
        push_cmd(4'd5, 16'd0, 16'd0, 1'b1);
        pop_res(2, lat);
        chk("div0_err", 32'(res_err), 32'd2);
        chk("div0_acc", acc, 32'd35);

        push_cmd(4'd3, 16'd11, 16'd51, 1'b0);
        pop_res(0, lat);
        chk("sub_data", res_data, 32'hFFFF_FFD8);
        push_cmd(4'd4, 16'd3, 16'd0, 1'b0);
        pop_res(0, lat);
        chk("mul0_err", 32'(res_err), 32'd0);

        // Fill with RES_READY low: one in flight plus DEPTH queued.
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            if (!cmd_ready) break;
            push_cmd(4'd2, 16'(i * 3), 16'(i + 1), 1'b0);
            accepted++;
        end
        chk("fill_count", 32'(accepted), 32'(DEPTH + 1));
        chk("full_ready", 32'(cmd_ready), 32'd0);
        chk("full_busy", 32'(busy), 32'd1);
        for (int i = 0; i < DEPTH + 1; i++) pop_res(0, lat);
        chk("drain_busy", 32'(busy), 32'd0);

        // Reset while the head is settling with two commands queued.
        push_cmd(4'd2, 16'd100, 16'd200, 1'b0);
        push_cmd(4'd4, 16'd9, 16'd9, 1'b0);
        push_cmd(4'd1, 16'd77, 16'd0, 1'b0);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_hi_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        acc_m = 0;
        chk("midrst_valid", 32'(res_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_acc", acc, 32'd0);
        chk("midrst_data", res_data, 32'd0);
        chk("midrst_alu_op", 32'(alu_op), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_valid", 32'(res_valid), 32'd0);
        end
        push_cmd(4'd2, 16'd1, 16'd1, 1'b0);
        pop_res(0, lat);
        chk("post_rst_add", res_data, 32'd2);

        // Illegal op completes locally with both flags; then CLR.
        push_cmd(4'd10, 16'd4, 16'd4, 1'b0);
        pop_res(0, lat);
        chk("illegal_latency", 32'(lat), 32'd1);
        chk("illegal_acc", acc, 32'd2);
        push_cmd(4'd0, 16'd0, 16'd0, 1'b0);
        pop_res(0, lat);
        chk("clr_acc", acc, 32'd0);

        for (int it = 0; it < 15; it++) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                r   = $urandom_range(0, 9);
                rop = (r < 7) ? 4'(2 + (r % 5)) : 4'($urandom_range(0, 15));
                ra  = 16'($urandom);
                rb  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 300));
                push_cmd(rop, ra, rb, 1'($urandom_range(0, 1)));
            end
            for (int k = 0; k < n; k++) pop_res($urandom_range(0, 2), lat);
        end
        chk("final_busy", 32'(busy), 32'd0);
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
